clk_div_gen: RTL and testbench

- Synthesizable, parametrised successor to the behavioural testbench clock source.
- Derives CHANNELS independent divided clocks from the single system clock `clk`.
- Each channel has a programmable period and high time, a run/stop control and single-cycle edge ticks.
- Sits beside the control unit; feeds timers, peripheral strobes and slow-domain enables without new clock trees.

---
 rtl/clk_div_gen.sv | 200 ++++++++++++++++++++
 tb/tb_clk_div_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// clk_div_gen: CHANNELS programmable divided clocks with single-cycle edge ticks, all derived from clk.
// Latency: every output is registered; a sampled run, sync or config write shows up one cycle later.
// Backpressure: none; writes to a valid channel are always taken (last write wins) and acked next cycle.
// Optional start phase: define CLK_DIV_GEN_PHASE_EN to add the cfg_phase input.
module clk_div_gen #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int DEF_DIV  = 2
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               cfg_wr,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                                   cfg_div,
    input  logic [CNT_W-1:0]                                   cfg_high,
`ifdef CLK_DIV_GEN_PHASE_EN
    input  logic [CNT_W-1:0]                                   cfg_phase,
`endif
    output logic                                               cfg_ack,
    input  logic [CHANNELS-1:0]                                run,
    input  logic                                               sync,
    output logic [CHANNELS-1:0]                                clk_out,
    output logic [CHANNELS-1:0]                                tick_rise,
    output logic [CHANNELS-1:0]                                tick_fall,
    output logic [CHANNELS-1:0]                                busy
);

    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CH_W1   = CH_W + 1;
    localparam int DEF_D_I = (DEF_DIV < 2) ? 2 : DEF_DIV;
    localparam int DEF_H_R = ((DEF_DIV / 2) == 0) ? 1 : (DEF_DIV / 2);
    localparam int DEF_H_I = (DEF_H_R >= DEF_D_I) ? (DEF_D_I - 1) : DEF_H_R;
    localparam logic [CNT_W-1:0] DEF_D  = CNT_W'(DEF_D_I);
    localparam logic [CNT_W-1:0] DEF_H  = CNT_W'(DEF_H_I);
    localparam logic [CH_W:0]    CH_LIM = CH_W1'(CHANNELS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // Period is at least 2 so every period has a high and a low cycle.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(2)) ? CNT_W'(2) : d;
    endfunction

    // High time is 1..d-1 against an already clamped period d.
    function automatic logic [CNT_W-1:0] clamp_high(input logic [CNT_W-1:0] d,
                                                    input logic [CNT_W-1:0] h);
        if (h == '0)
            return CNT_W'(1);
        else if (h >= d)
            return d - CNT_W'(1);
        else
            return h;
    endfunction

    state_t              r_state    [CHANNELS];
    state_t              w_state_nx [CHANNELS];
    logic [CNT_W-1:0]    r_cnt      [CHANNELS];
    logic [CNT_W-1:0]    r_div      [CHANNELS];
    logic [CNT_W-1:0]    r_high     [CHANNELS];
    logic [CNT_W-1:0]    r_sh_div   [CHANNELS];
    logic [CNT_W-1:0]    r_sh_high  [CHANNELS];
    logic [CNT_W-1:0]    w_cnt_nx   [CHANNELS];
    logic [CNT_W-1:0]    w_div_eff  [CHANNELS];
    logic [CNT_W-1:0]    w_high_eff [CHANNELS];
    logic [CNT_W-1:0]    w_start    [CHANNELS];
`ifdef CLK_DIV_GEN_PHASE_EN
    logic [CNT_W-1:0]    r_phase     [CHANNELS];
    logic [CNT_W-1:0]    r_sh_phase  [CHANNELS];
    logic [CNT_W-1:0]    w_phase_eff [CHANNELS];
`endif
    logic [CHANNELS-1:0] r_clk_out;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] r_busy;
    logic [CHANNELS-1:0] w_clk_nx;
    logic [CHANNELS-1:0] w_wr_hit;
    logic [CHANNELS-1:0] w_wrap;
    logic [CHANNELS-1:0] w_apply;
    logic                r_ack;
    logic                w_ch_ok;

    // Decode the write target, period wrap, and whether pending config takes effect at this edge.
    always_comb begin
        w_ch_ok = ({1'b0, cfg_ch} < CH_LIM);
        for (int i = 0; i < CHANNELS; i++) begin
            w_wr_hit[i]   = cfg_wr && w_ch_ok && (cfg_ch == CH_W'(i));
            w_wrap[i]     = (r_cnt[i] == (r_div[i] - CNT_W'(1)));
            // Config lands only on a period boundary (wrap or sync), or immediately when idle.
            w_apply[i]    = r_busy[i] && ((r_state[i] == ST_IDLE) || sync || w_wrap[i]);
            w_div_eff[i]  = w_apply[i] ? clamp_div(r_sh_div[i]) : r_div[i];
            w_high_eff[i] = w_apply[i] ? clamp_high(clamp_div(r_sh_div[i]), r_sh_high[i])
                                       : r_high[i];
`ifdef CLK_DIV_GEN_PHASE_EN
            w_phase_eff[i] = w_apply[i] ? r_sh_phase[i] : r_phase[i];
            w_start[i]     = w_phase_eff[i] % w_div_eff[i];
`else
            w_start[i]     = '0;
`endif
        end
    end

    // Per-channel FSM next state: counter, divided clock level and run/stop sequencing.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            w_clk_nx[i]   = r_clk_out[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (run[i]) begin
                        w_state_nx[i] = ST_RUN;
                        w_cnt_nx[i]   = w_start[i];
                        w_clk_nx[i]   = (w_start[i] < w_high_eff[i]);
                    end
                end
                default: begin
                    if (sync) begin
                        // Realign: restart the period from the start point, keep run/stop intent.
                        w_state_nx[i] = run[i] ? ST_RUN : ST_STOP;
                        w_cnt_nx[i]   = w_start[i];
                        w_clk_nx[i]   = (w_start[i] < w_high_eff[i]);
                    end else if (w_wrap[i]) begin
                        if (!run[i]) begin
                            // Period finished with run low: park low without a rising tick.
                            w_state_nx[i] = ST_IDLE;
                            w_cnt_nx[i]   = '0;
                            w_clk_nx[i]   = 1'b0;
                        end else begin
                            w_state_nx[i] = ST_RUN;
                            w_cnt_nx[i]   = '0;
                            w_clk_nx[i]   = (CNT_W'(0) < w_high_eff[i]);
                        end
                    end else begin
                        // Mid-period: the period always completes; run only picks the state.
                        w_state_nx[i] = run[i] ? ST_RUN : ST_STOP;
                        w_cnt_nx[i]   = r_cnt[i] + CNT_W'(1);
                        w_clk_nx[i]   = ((r_cnt[i] + CNT_W'(1)) < r_high[i]);
                    end
                end
            endcase
        end
    end

    // State, counters, active/shadow config and registered outputs; reset discards any shadow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i]   <= ST_IDLE;
                r_cnt[i]     <= '0;
                r_div[i]     <= DEF_D;
                r_high[i]    <= DEF_H;
                r_sh_div[i]  <= DEF_D;
                r_sh_high[i] <= DEF_H;
`ifdef CLK_DIV_GEN_PHASE_EN
                r_phase[i]    <= '0;
                r_sh_phase[i] <= '0;
`endif
            end
            r_clk_out <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_busy    <= '0;
            r_ack     <= 1'b0;
        end else begin
            r_ack     <= cfg_wr && w_ch_ok;
            r_rise    <= ~r_clk_out & w_clk_nx;
            r_fall    <= r_clk_out & ~w_clk_nx;
            r_clk_out <= w_clk_nx;
            // A write in the same cycle as an apply stays pending for the next boundary.
            r_busy    <= w_wr_hit | (r_busy & ~w_apply);
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
                r_div[i]   <= w_div_eff[i];
                r_high[i]  <= w_high_eff[i];
`ifdef CLK_DIV_GEN_PHASE_EN
                r_phase[i] <= w_phase_eff[i];
`endif
                if (w_wr_hit[i]) begin
                    r_sh_div[i]  <= cfg_div;
                    r_sh_high[i] <= cfg_high;
`ifdef CLK_DIV_GEN_PHASE_EN
                    r_sh_phase[i] <= cfg_phase;
`endif
                end
            end
        end
    end

    assign clk_out   = r_clk_out;
    assign tick_rise = r_rise;
    assign tick_fall = r_fall;
    assign busy      = r_busy;
    assign cfg_ack   = r_ack;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed vector table for clk_div_gen, five channels so an out-of-range cfg_ch exists.
// Each row: inputs driven on the falling edge, outputs compared 1 time unit after the next rising edge.
// An async reset mid-cycle sits between the two halves of the table.
module tb_clk_div_gen;

    localparam int CH = 5;
    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          cfg_wr;
    logic [2:0]    cfg_ch;
    logic [CW-1:0] cfg_div;
    logic [CW-1:0] cfg_high;
`ifdef CLK_DIV_GEN_PHASE_EN
    logic [CW-1:0] cfg_phase;
`endif
    logic          cfg_ack;
    logic [CH-1:0] run;
    logic          sync;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick_rise;
    logic [CH-1:0] tick_fall;
    logic [CH-1:0] busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0]  run;
        logic        sync;
        logic        wr;
        logic [2:0]  ch;
        logic [15:0] div;
        logic [15:0] high;
        logic [4:0]  e_clk;
        logic [4:0]  e_rise;
        logic [4:0]  e_fall;
        logic        e_ack;
        logic [4:0]  e_busy;
    } vec_t;

    vec_t tbl[$];

    clk_div_gen #(
        .CHANNELS (CH),
        .CNT_W    (CW),
        .DEF_DIV  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
`ifdef CLK_DIV_GEN_PHASE_EN
        .cfg_phase (cfg_phase),
`endif
        .cfg_ack   (cfg_ack),
        .run       (run),
        .sync      (sync),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] r, input logic s, input logic w, input logic [2:0] c,
                       input logic [15:0] d, input logic [15:0] h,
                       input logic [4:0] ec, input logic [4:0] er, input logic [4:0] ef,
                       input logic ea, input logic [4:0] eb);
        vec_t v;
        v.run = r;  v.sync = s;  v.wr = w;  v.ch = c;  v.div = d;  v.high = h;
        v.e_clk = ec;  v.e_rise = er;  v.e_fall = ef;  v.e_ack = ea;  v.e_busy = eb;
        tbl.push_back(v);
    endtask

    task automatic run_row(input int k);
        @(negedge clk);
        run      = tbl[k].run;
        sync     = tbl[k].sync;
        cfg_wr   = tbl[k].wr;
        cfg_ch   = tbl[k].ch;
        cfg_div  = tbl[k].div;
        cfg_high = tbl[k].high;
        @(posedge clk);
        #1;
        chk("clk_out",   k + 1, clk_out,          tbl[k].e_clk);
        chk("tick_rise", k + 1, tick_rise,        tbl[k].e_rise);
        chk("tick_fall", k + 1, tick_fall,        tbl[k].e_fall);
        chk("cfg_ack",   k + 1, {4'b0, cfg_ack},  {4'b0, tbl[k].e_ack});
        chk("busy",      k + 1, busy,             tbl[k].e_busy);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_clk_out"},   0, clk_out,         5'b0);
        chk({tag, "_tick_rise"}, 0, tick_rise,       5'b0);
        chk({tag, "_tick_fall"}, 0, tick_fall,       5'b0);
        chk({tag, "_cfg_ack"},   0, {4'b0, cfg_ack}, 5'b0);
        chk({tag, "_busy"},      0, busy,            5'b0);
    endtask

    initial begin
        reset = 1'b1;  cfg_wr = 1'b0;  cfg_ch = 3'd0;  cfg_div = '0;  cfg_high = '0;
        run = '0;  sync = 1'b0;
`ifdef CLK_DIV_GEN_PHASE_EN
        cfg_phase = '0;
`endif

        //   run       sy wr ch    div     high     clk_out   rise      fall     ack busy
        // ch0 default div=2 high=1
        add(5'b00001, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00001, 5'b00001, 5'b00000, 0, 5'b00000); // 1
        add(5'b00001, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00000, 5'b00000, 5'b00001, 0, 5'b00000);
        add(5'b00001, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00001, 5'b00001, 5'b00000, 0, 5'b00000);
        add(5'b00001, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00000, 5'b00000, 5'b00001, 0, 5'b00000);
        // program ch1 div=5 high=2, then start it: 11000 pattern
        add(5'b00001, 0, 1, 3'd1, 16'd5, 16'd2,  5'b00001, 5'b00001, 5'b00000, 1, 5'b00010); // 5
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00010, 5'b00010, 5'b00001, 0, 5'b00000);
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00011, 5'b00001, 5'b00000, 0, 5'b00000);
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00000, 5'b00000, 5'b00011, 0, 5'b00000);
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00001, 5'b00001, 5'b00000, 0, 5'b00000);
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00000, 5'b00000, 5'b00001, 0, 5'b00000); // 10
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00011, 5'b00011, 5'b00000, 0, 5'b00000);
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00010, 5'b00000, 5'b00001, 0, 5'b00000);
        // reprogram ch1 div=4 high=1 at cnt=1: old period finishes first
        add(5'b00011, 0, 1, 3'd1, 16'd4, 16'd1,  5'b00001, 5'b00001, 5'b00010, 1, 5'b00010);
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00000, 5'b00000, 5'b00001, 0, 5'b00010);
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00001, 5'b00001, 5'b00000, 0, 5'b00010); // 15
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00010, 5'b00010, 5'b00001, 0, 5'b00000);
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00001, 5'b00001, 5'b00010, 0, 5'b00000);
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00000, 5'b00000, 5'b00001, 0, 5'b00000);
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00001, 5'b00001, 5'b00000, 0, 5'b00000);
        add(5'b00011, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00010, 5'b00010, 5'b00001, 0, 5'b00000); // 20
        // clamping: ch2 div=0 high=9 behaves as div=2 high=1
        add(5'b00011, 0, 1, 3'd2, 16'd0, 16'd9,  5'b00001, 5'b00001, 5'b00010, 1, 5'b00100);
        add(5'b00111, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00100, 5'b00100, 5'b00001, 0, 5'b00000);
        add(5'b00111, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00001, 5'b00001, 5'b00100, 0, 5'b00000);
        add(5'b00111, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00110, 5'b00110, 5'b00001, 0, 5'b00000);
        // out-of-range channels 7 and 5: no ack, no busy, ch1 keeps its 4-cycle period
        add(5'b00111, 0, 1, 3'd7, 16'd9, 16'd3,  5'b00001, 5'b00001, 5'b00110, 0, 5'b00000); // 25
        add(5'b00111, 0, 1, 3'd5, 16'd9, 16'd3,  5'b00100, 5'b00100, 5'b00001, 0, 5'b00000);
        add(5'b00111, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00001, 5'b00001, 5'b00100, 0, 5'b00000);
        add(5'b00111, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00110, 5'b00110, 5'b00001, 0, 5'b00000);
        // drop run[1] while high: period completes, then quiet with no ticks
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00001, 5'b00001, 5'b00110, 0, 5'b00000);
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00100, 5'b00100, 5'b00001, 0, 5'b00000); // 30
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00001, 5'b00001, 5'b00100, 0, 5'b00000);
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00100, 5'b00100, 5'b00001, 0, 5'b00000);
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00001, 5'b00001, 5'b00100, 0, 5'b00000);
        // sync with ch0 high and ch2 low: both restart high, rise only on ch2
        add(5'b00101, 1, 0, 3'd0, 16'd0, 16'd0,  5'b00101, 5'b00100, 5'b00000, 0, 5'b00000);
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00000, 5'b00000, 5'b00101, 0, 5'b00000); // 35
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00101, 5'b00101, 5'b00000, 0, 5'b00000);
        // ch0 run drops then returns at the period end: seamless continuation
        add(5'b00100, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00000, 5'b00000, 5'b00101, 0, 5'b00000);
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00101, 5'b00101, 5'b00000, 0, 5'b00000);
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00000, 5'b00000, 5'b00101, 0, 5'b00000);
        // leave a pending div=7 shadow on ch2 just before the reset
        add(5'b00101, 0, 1, 3'd2, 16'd7, 16'd3,  5'b00101, 5'b00101, 5'b00000, 1, 5'b00100); // 40
        // after reset: defaults again, pending shadow gone
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00101, 5'b00101, 5'b00000, 0, 5'b00000);
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00000, 5'b00000, 5'b00101, 0, 5'b00000);
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00101, 5'b00101, 5'b00000, 0, 5'b00000);
        // sync together with a write to ch0: new shadow waits for the following wrap
        add(5'b00101, 1, 1, 3'd0, 16'd6, 16'd3,  5'b00101, 5'b00000, 5'b00000, 1, 5'b00001);
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00000, 5'b00000, 5'b00101, 0, 5'b00001); // 45
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00101, 5'b00101, 5'b00000, 0, 5'b00000);
        add(5'b00101, 0, 0, 3'd0, 16'd0, 16'd0,  5'b00001, 5'b00000, 5'b00100, 0, 5'b00000);

        #1;
        chk_all_zero("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 40; k++) run_row(k);

        // Async reset between edges: outputs must drop without waiting for a clock.
        #1;
        reset = 1'b1;  run = '0;  cfg_wr = 1'b0;  sync = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;

        for (int k = 40; k < tbl.size(); k++) run_row(k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
